// File: rtl/fft_iter_engine.sv
// Iterative radix-2 DIT FFT/IFFT engine: bit-reversed load, one in-place butterfly per cycle, natural-order unload.
// Optional macro FFT_STAGE_SCALE_EN: halve every butterfly result (gain 1/N) instead of saturating (gain 1).
module fft_iter_engine #(
    parameter int unsigned N_LOG2 = 3,
    parameter int unsigned DW     = 16,
    parameter int unsigned TW_W   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_real,
    input  logic [DW-1:0]     in_imag,
    input  logic              start,
    input  logic              inverse,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_real,
    output logic [DW-1:0]     out_imag,
    output logic [N_LOG2-1:0] out_index,
    output logic              busy,
    output logic              done
);
    localparam int unsigned N   = 1 << N_LOG2;
    localparam int unsigned KW  = N_LOG2 - 1;
    localparam int unsigned SW  = 4;
    localparam int unsigned MW  = DW + TW_W;
    localparam int unsigned PW  = MW + 1;
    localparam int unsigned XW  = DW + 2;
    localparam int unsigned SHR = TW_W - 2;
    localparam int unsigned ONE = 1 << SHR;

    localparam logic signed [PW-1:0] RND        = PW'(1 << (TW_W - 3));
    localparam logic [N_LOG2-1:0]    LAST_IDX   = N_LOG2'(N - 1);
    localparam logic [SW-1:0]        LAST_STAGE = SW'(N_LOG2 - 1);
    localparam logic [KW-1:0]        LAST_K     = {KW{1'b1}};
`ifdef FFT_STAGE_SCALE_EN
    localparam logic signed [XW-1:0] ONE_X      = XW'(1);
`else
    localparam logic signed [XW-1:0] SAT_HI     = XW'((1 << (DW - 1)) - 1);
    localparam logic signed [XW-1:0] SAT_LO     = ~SAT_HI;
`endif

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOADED, S_COMPUTE, S_UNLOAD} state_t;

    // Twiddle value in Q2.(TW_W-2), rounded to nearest, evaluated at elaboration.
    function automatic int tw_value(input int t, input bit want_sin);
        real ang;
        real v;
        ang = 6.283185307179586 * real'(t) / real'(N);
        v   = (want_sin ? $sin(ang) : $cos(ang)) * real'(ONE);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
        logic [N_LOG2-1:0] r;
        for (int i = 0; i < N_LOG2; i++) r[i] = v[N_LOG2-1-i];
        return r;
    endfunction

    // Final narrowing of a DW+2 bit butterfly result back to DW.
    function automatic logic [DW-1:0] reduce(input logic signed [XW-1:0] v);
`ifdef FFT_STAGE_SCALE_EN
        logic signed [XW-1:0] s;
        s = (v + ONE_X) >>> 1;
        return DW'(s);
`else
        if (v > SAT_HI) return DW'(SAT_HI);
        if (v < SAT_LO) return DW'(SAT_LO);
        return DW'(v);
`endif
    endfunction

    logic signed [TW_W-1:0] tw_cos [N/2];
    logic signed [TW_W-1:0] tw_sin [N/2];

    for (genvar g = 0; g < N / 2; g++) begin : g_tw
        localparam int COS_V = tw_value(g, 1'b0);
        localparam int SIN_V = tw_value(g, 1'b1);
        assign tw_cos[g] = TW_W'(COS_V);
        assign tw_sin[g] = TW_W'(SIN_V);
    end

    logic signed [DW-1:0] buf_re [N];
    logic signed [DW-1:0] buf_im [N];

    state_t            state_q, state_d;
    logic [N_LOG2-1:0] cnt_q, cnt_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic [KW-1:0]     k_q, k_d;
    logic              inv_q, inv_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DW-1:0]     out_re_q, out_re_d;
    logic [DW-1:0]     out_im_q, out_im_d;
    logic [N_LOG2-1:0] out_idx_q, out_idx_d;
    logic [N_LOG2-1:0] nxt_idx;
    logic              load_we, bfly_we;

    logic [N_LOG2-1:0]    half, mask, k_ext, top, bot;
    logic [SW-1:0]        shamt;
    logic [KW-1:0]        tw_idx;
    logic signed [MW-1:0] w_re, w_im, b_re, b_im;
    logic signed [MW-1:0] m_rr, m_ii, m_ri, m_ir;
    logic signed [PW-1:0] p_re_f, p_im_f;
    logic signed [XW-1:0] p_re, p_im, a_re, a_im;
    logic signed [XW-1:0] sum_re, sum_im, dif_re, dif_im;
    logic [DW-1:0]        top_re_n, top_im_n, bot_re_n, bot_im_n;

    // Butterfly datapath for the current (stage, k); results are written back at the clock edge.
    always_comb begin : bfly
        half   = N_LOG2'(1) << stage_q;
        mask   = half - N_LOG2'(1);
        k_ext  = N_LOG2'(k_q);
        top    = ((k_ext >> stage_q) << (stage_q + SW'(1))) | (k_ext & mask);
        bot    = top + half;
        shamt  = LAST_STAGE - stage_q;
        tw_idx = KW'(k_ext & mask) << shamt;
        w_re   = MW'(tw_cos[tw_idx]);
        w_im   = inv_q ? MW'(tw_sin[tw_idx]) : -MW'(tw_sin[tw_idx]);
        b_re   = MW'(buf_re[bot]);
        b_im   = MW'(buf_im[bot]);
        m_rr   = w_re * b_re;
        m_ii   = w_im * b_im;
        m_ri   = w_re * b_im;
        m_ir   = w_im * b_re;
        p_re_f = PW'(m_rr) - PW'(m_ii) + RND;
        p_im_f = PW'(m_ri) + PW'(m_ir) + RND;
        p_re   = XW'(p_re_f >>> SHR);
        p_im   = XW'(p_im_f >>> SHR);
        a_re   = XW'(buf_re[top]);
        a_im   = XW'(buf_im[top]);
        sum_re = a_re + p_re;
        sum_im = a_im + p_im;
        dif_re = a_re - p_re;
        dif_im = a_im - p_im;
        top_re_n = reduce(sum_re);
        top_im_n = reduce(sum_im);
        bot_re_n = reduce(dif_re);
        bot_im_n = reduce(dif_im);
    end

    always_comb begin : fsm_next
        state_d   = state_q;
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        k_d       = k_q;
        inv_d     = inv_q;
        out_re_d  = out_re_q;
        out_im_d  = out_im_q;
        out_idx_d = out_idx_q;
        done_d    = 1'b0;
        load_we   = 1'b0;
        bfly_we   = 1'b0;
        nxt_idx   = out_idx_q + N_LOG2'(1);
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    load_we = 1'b1;
                    cnt_d   = cnt_q + N_LOG2'(1);
                    if (cnt_q == LAST_IDX) state_d = S_LOADED;
                end
            end
            S_LOADED: begin
                if (start) begin
                    inv_d   = inverse;
                    stage_d = '0;
                    k_d     = '0;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                bfly_we = 1'b1;
                k_d     = k_q + KW'(1);
                if (k_q == LAST_K) begin
                    stage_d = stage_q + SW'(1);
                    // Bin 0 is final well before the last butterfly, so it can be presented now.
                    if (stage_q == LAST_STAGE) begin
                        stage_d   = '0;
                        state_d   = S_UNLOAD;
                        out_idx_d = '0;
                        out_re_d  = buf_re[0];
                        out_im_d  = buf_im[0];
                    end
                end
            end
            S_UNLOAD: begin
                if (out_ready) begin
                    if (out_idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        out_idx_d = nxt_idx;
                        out_re_d  = buf_re[nxt_idx];
                        out_im_d  = buf_im[nxt_idx];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_LOAD);
        out_valid_d = (state_d == S_UNLOAD);
        busy_d      = (state_d == S_COMPUTE) || (state_d == S_UNLOAD);
    end

    always_ff @(posedge CLK) begin : state_reg
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            stage_q     <= '0;
            k_q         <= '0;
            inv_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            k_q         <= k_d;
            inv_q       <= inv_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_idx_q   <= out_idx_d;
        end
    end

    // Sample buffer: bit-reversed writes during load, in-place butterfly writes during compute.
    always_ff @(posedge CLK) begin : buf_wr
        if (load_we) begin
            buf_re[bitrev(cnt_q)] <= in_real;
            buf_im[bitrev(cnt_q)] <= in_imag;
        end
        if (bfly_we) begin
            buf_re[top] <= top_re_n;
            buf_im[top] <= top_im_n;
            buf_re[bot] <= bot_re_n;
            buf_im[bot] <= bot_im_n;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_real  = out_re_q;
    assign out_imag  = out_im_q;
    assign out_index = out_idx_q;

endmodule

// File: tb/tb_fft_iter_engine.sv
// Directed bench for fft_iter_engine (N=8): known spectra, impulse, saturation, backpressure, protocol, reset abort.
module tb_fft_iter_engine;
    localparam int unsigned N_LOG2 = 3;
    localparam int unsigned DW     = 16;
    localparam int unsigned TW_W   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, start, inverse;
    logic [DW-1:0]     in_real, in_imag;
    logic              out_valid, out_ready, busy, done;
    logic [DW-1:0]     out_real, out_imag;
    logic [N_LOG2-1:0] out_index;

    int n_vec = 0;
    int n_err = 0;
    int res_re [8];
    int res_im [8];

    always #5 clk = ~clk;

    fft_iter_engine #(.N_LOG2(N_LOG2), .DW(DW), .TW_W(TW_W)) dut (
        .CLK(clk), .RST(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
        .start(start), .inverse(inverse),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag), .out_index(out_index),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input int got, input int exp, input int tol);
        int d;
        n_vec++;
        d = got - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // Enter at posedge+1; returns at posedge+1 after the 8th accepted sample.
    task automatic load_frame(input int re [8], input int im [8], input bit hold_start);
        int t;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_real  = DW'(re[i]);
            in_imag  = DW'(im[i]);
            start    = hold_start && (i < 7);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!in_ready && t < 50);
            chk($sformatf("load%0d in_ready", i), int'(in_ready), 1, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // Pulse start, then collect the unload; stall=1 drives out_ready 1,0,0,1,0,0,...
    task automatic run_fft(input bit inv, input bit stall, input string tag);
        int c, exp_idx, busy_cyc, first_valid, done_cnt, done_at, last_xfer;
        int h_re, h_im, h_idx;
        bit held, rdy;
        c = 0; exp_idx = 0; busy_cyc = 0; first_valid = -1; done_cnt = 0;
        done_at = -1; last_xfer = -1; held = 1'b0; h_re = 0; h_im = 0; h_idx = 0;
        start = 1'b1; inverse = inv;
        @(posedge clk); #1;
        start = 1'b0; inverse = 1'b0;
        while (c < 300 && (done_at < 0 || c < done_at + 2)) begin
            c++;
            rdy = stall ? (((c - 1) % 3) == 0) : 1'b1;
            out_ready = rdy;
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = c;
                if (held) begin
                    chk({tag, " stall re"}, int'($signed(out_real)), h_re, 0);
                    chk({tag, " stall im"}, int'($signed(out_imag)), h_im, 0);
                    chk({tag, " stall idx"}, int'(out_index), h_idx, 0);
                end
                chk({tag, " idx order"}, int'(out_index), exp_idx, 0);
                held  = !rdy;
                h_re  = int'($signed(out_real));
                h_im  = int'($signed(out_imag));
                h_idx = int'(out_index);
                if (rdy) begin
                    if (exp_idx < 8) begin
                        res_re[exp_idx] = int'($signed(out_real));
                        res_im[exp_idx] = int'($signed(out_imag));
                    end
                    exp_idx++;
                    last_xfer = c;
                end
            end else begin
                held = 1'b0;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk({tag, " first valid cycle"}, first_valid, 13, 0);
        chk({tag, " transfers"}, exp_idx, 8, 0);
        chk({tag, " busy cycles"}, busy_cyc, stall ? 34 : 20, 0);
        chk({tag, " done count"}, done_cnt, 1, 0);
        chk({tag, " done after last"}, done_at, last_xfer + 1, 0);
    endtask

    task automatic check_bins(input string tag, input int er [8], input int ei [8]);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s X%0d re", tag, i), res_re[i], er[i], 1);
            chk($sformatf("%s X%0d im", tag, i), res_im[i], ei[i], 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " in_ready"}, int'(in_ready), 0, 0);
        chk({tag, " out_valid"}, int'(out_valid), 0, 0);
        chk({tag, " busy"}, int'(busy), 0, 0);
        chk({tag, " done"}, int'(done), 0, 0);
        chk({tag, " out_real"}, int'(out_real), 0, 0);
        chk({tag, " out_imag"}, int'(out_imag), 0, 0);
        chk({tag, " out_index"}, int'(out_index), 0, 0);
    endtask

    initial begin
        int zero [8], x1_re [8], imp_re [8], sat_re [8];
        int t1_re [8], t1_im [8], imp_e [8], sat_e [8];
        int n_done;
        zero   = '{0, 0, 0, 0, 0, 0, 0, 0};
        x1_re  = '{50, 50, 50, 50, 0, 0, 0, 0};
        imp_re = '{1000, 0, 0, 0, 0, 0, 0, 0};
        sat_re = '{20000, 20000, 20000, 20000, 20000, 20000, 20000, 20000};
`ifdef FFT_STAGE_SCALE_EN
        t1_re = '{25, 6, 0, 6, 0, 6, 0, 6};
        t1_im = '{0, -15, 0, -3, 0, 3, 0, 15};
        imp_e = '{125, 125, 125, 125, 125, 125, 125, 125};
        sat_e = '{20000, 0, 0, 0, 0, 0, 0, 0};
`else
        t1_re = '{200, 50, 0, 50, 0, 50, 0, 50};
        t1_im = '{0, -121, 0, -21, 0, 21, 0, 121};
        imp_e = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
        sat_e = '{32767, 0, 0, 0, 0, 0, 0, 0};
`endif
        rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0;
        start = 1'b0; inverse = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        load_frame(x1_re, zero, 1'b0);
        run_fft(1'b0, 1'b0, "t1");
        check_bins("t1", t1_re, t1_im);

        load_frame(imp_re, zero, 1'b0);
        run_fft(1'b0, 1'b0, "imp fwd");
        check_bins("imp fwd", imp_e, zero);
        load_frame(imp_re, zero, 1'b0);
        run_fft(1'b1, 1'b0, "imp inv");
        check_bins("imp inv", imp_e, zero);

        load_frame(sat_re, zero, 1'b0);
        run_fft(1'b0, 1'b0, "sat");
        check_bins("sat", sat_e, zero);

        load_frame(x1_re, zero, 1'b0);
        run_fft(1'b0, 1'b1, "bp");
        check_bins("bp", t1_re, t1_im);

        // start held through IDLE and LOAD must not launch a transform
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle start busy", int'(busy), 0, 0);
        @(posedge clk); #1;
        load_frame(x1_re, zero, 1'b1);
        in_valid = 1'b1;
        @(negedge clk);
        chk("ninth in_ready", int'(in_ready), 0, 0);
        chk("loaded busy", int'(busy), 0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("loaded idle busy", int'(busy), 0, 0);
        @(posedge clk); #1;
        run_fft(1'b0, 1'b0, "proto");
        check_bins("proto", t1_re, t1_im);

        // reset during the 5th compute cycle
        load_frame(x1_re, zero, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort no done", n_done, 0, 0);
        @(posedge clk); #1;
        load_frame(x1_re, zero, 1'b0);
        run_fft(1'b0, 1'b0, "reload");
        check_bins("reload", t1_re, t1_im);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
